// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester + data_memory bus for mem_arbiter.
// slave modport is the arbiter's view; master modport is the environment's view
// (cache requesters and data_memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;
  logic              stall_m;
  logic              stall_f;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_rdata,
    output d_done, i_done, rdata, mem_addr, mem_we, mem_wdata,
           busy, owner, stall_m, stall_f
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_rdata,
    input  d_done, i_done, rdata, mem_addr, mem_we, mem_wdata,
           busy, owner, stall_m, stall_f
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide data_memory between the data cache
// (refill/writeback) and the instruction-cache refill port. One transaction in
// flight; memory latency modelled by a down-counter (MEM_LAT cycles in ACCESS).
// Optional build macro MEM_ARBITER_ROUND_ROBIN_EN: on a tie, grant the side
// opposite the previous grant; otherwise data side always wins.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int MEM_LAT = 20
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [4:0]        CNT_LOAD   = 5'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              grant_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // tie goes to the side that was not granted last
  assign grant_i = bus.i_req & (~bus.d_req | ~last_owner_q);

  // previous-grant register for round-robin tie breaking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_owner_q <= 1'b1;
    else        last_owner_q <= last_owner_d;
  end

  // record the winner at every grant
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && (bus.d_req || bus.i_req)) last_owner_d = grant_i;
  end
`else
  // fixed priority: data side beats instruction side
  assign grant_i = bus.i_req & ~bus.d_req;
`endif

  // state and latched-request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // next-state: grant in IDLE, count down in ACCESS, single DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          owner_d = grant_i;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          if (grant_i) begin
            addr_d = bus.i_addr & ALIGN_MASK;
            we_d   = 1'b0;
          end else begin
            addr_d  = bus.d_addr & ALIGN_MASK;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state_q == ACCESS) && (cnt_q == '0) && we_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
  assign bus.d_done    = (state_q == DONE) && !owner_q;
  assign bus.i_done    = (state_q == DONE) && owner_q;
  assign bus.stall_m   = bus.d_req & ~bus.d_done;
  assign bus.stall_f   = bus.i_req & ~bus.i_done;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single 128-bit line-wide data_memory between two requesters: the data cache (refill/writeback) and an instruction-cache refill port.
- Models main-memory latency with a down-counter and exposes per-port stall signals to the hazard logic.
- Sits between the cache blocks and data_memory in the MEM stage.
- Exactly one transaction is in flight at a time; there is no buffering beyond the latched request.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, memory line width in bits.
- MEM_LAT, 20, cycles spent in ACCESS per transaction; legal range 1 to 31.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- d_req  in  1  data-side request; level, held until d_done.
- d_we  in  1  1 = line write (writeback), 0 = line read (refill).
- d_addr  in  ADDR_W  data-side byte address.
- d_wdata  in  LINE_W  writeback line.
- d_done  out  1  one-cycle completion pulse, data side.
- i_req  in  1  instruction-side read request; level, held until i_done.
- i_addr  in  ADDR_W  instruction-side byte address.
- i_done  out  1  one-cycle completion pulse, instruction side.
- rdata  out  LINE_W  read line; valid with the done pulse and held until the next read capture.
- mem_addr  out  ADDR_W  line-aligned address to data_memory.
- mem_we  out  1  write strobe to data_memory.
- mem_wdata  out  LINE_W  write line to data_memory.
- mem_rdata  in  LINE_W  read line from data_memory.
- busy  out  1  state is not IDLE.
- owner  out  1  0 = data side granted, 1 = instruction side granted.
- stall_m  out  1  d_req & ~d_done.
- stall_f  out  1  i_req & ~i_done.

Behaviour:
- Reset values (asynchronous, reset low):
  - state = IDLE; cnt = 0.
  - d_done = i_done = mem_we = busy = 0.
  - owner = 0; rdata = 0; mem_addr = 0; mem_wdata = 0.
  - last_owner = 1.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high at a clk edge, latch the winner, its address, d_we and d_wdata.
  - Set owner, load cnt = MEM_LAT-1, go to ACCESS.
  - If no req is high, stay in IDLE.
- Priority (default): d_req beats i_req. Instruction side may starve under continuous d_req; this is accepted.
- ACCESS:
  - mem_addr = {latched_addr[ADDR_W-1:4], 4'b0000}; mem_wdata = latched wdata.
  - cnt decrements each cycle.
  - mem_we is high only during the cycle cnt==0, and only for a write: exactly one strobe per write transaction.
  - At the edge ending the cnt==0 cycle:
    - Read transaction: rdata <= mem_rdata.
    - Write transaction: rdata is unchanged.
    - Go to DONE.
- DONE:
  - Assert the owner's done for exactly one cycle. The other done stays 0.
  - Go to IDLE. No new grant is issued in the DONE cycle.
- Latency: request sampled in IDLE at edge N; done high in cycle N+MEM_LAT+1. Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Requester protocol: drop or replace req on the edge where done is sampled high. A req still high in the following IDLE cycle is treated as a new transaction.
- Request withdrawn mid-transaction: ignored. The transaction completes and done still pulses.
- Input changes during ACCESS: addr and wdata changes are ignored because latched values are used.
- MEM_LAT=1: ACCESS lasts one cycle; mem_we and the capture happen in that cycle.
- Reset asserted mid-transaction: immediate return to IDLE. No mem_we pulse, no done pulse; the pending request is lost, so the requester re-issues it.
- stall_m and stall_f are combinational, so a requester stalls from the cycle req rises through the cycle before done.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: when both d_req and i_req are high in IDLE, grant the side opposite last_owner.
  - last_owner updates at every grant.
  - The reset value 1 means the data side wins the first tie.
  - A single requester is always granted immediately.
- Undefined: fixed data-over-instruction priority. last_owner is not implemented.

Test Plan:
- Data read: MEM_LAT=20, d_req=1, d_we=0, d_addr=0x0000_1234, mem_rdata=0xAAAA…AAAA -> mem_addr=0x0000_1230 for 20 cycles; d_done high exactly 21 cycles after the sampling edge; rdata=0xAAAA…AAAA; mem_we never high; i_done stays 0.
- Data write: d_we=1, d_addr=0x40, d_wdata=0x1111…1111 -> mem_we high for exactly 1 cycle (the 20th ACCESS cycle) with mem_addr=0x40 and mem_wdata=0x1111…1111; d_done the next cycle; rdata unchanged.
- Tie, default build: d_req and i_req rise in the same cycle -> data side served first (owner=0); instruction side granted in the IDLE cycle after d_done; stall_f stays high for 43 cycles.
- Tie with MEM_ARBITER_ROUND_ROBIN_EN: hold both requests across three transactions -> owner sequence 0, 1, 0.
- Reset mid-ACCESS: assert reset at cnt=10 of a write -> busy=0 and mem_we=0 immediately; no done pulse; after release with d_req held, a fresh 21-cycle transaction runs.
- MEM_LAT=1 with i_req only, i_addr=0xFFFF_FFFF -> mem_addr=0xFFFF_FFF0; i_done 2 cycles after sampling; back-to-back held request completes every 3 cycles.
